// File: rtl/synapse_pkg.sv
// rtl/synapse_pkg.sv - shared constants, fetch state type and clog2 helper for the synapse store
package synapse_pkg;

  localparam int          WB_WORD_W     = 32;
  localparam logic [31:0] SYN_BASE_ADDR = 32'h3000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/synapse_row_fetch_fsm.sv
// rtl/synapse_row_fetch_fsm.sv - row fetch sequencer: walks one axon row word by word when granted the port
module synapse_row_fetch_fsm
  import synapse_pkg::*;
#(
  parameter int NUM_AXONS = 256,
  parameter int WPR       = 8,
  parameter int AXW       = 8,
  parameter int IW        = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           row_req_i,
  input  logic [AXW-1:0] row_axon_i,
  input  logic           grant_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic           cap_en_o,
  output logic [IW-1:0]  word_idx_o,
  output logic [AXW-1:0] axon_o
);

  fetch_state_e   state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [AXW-1:0] axon_q, axon_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      axon_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      axon_q  <= axon_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    axon_d   = axon_q;
    busy_o   = 1'b0;
    valid_o  = 1'b0;
    cap_en_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (row_req_i) begin
          axon_d  = row_axon_i;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy_o = 1'b1;
        // Without the grant the counter simply holds; the word is retried next cycle.
        if (grant_i) begin
          cap_en_o = 1'b1;
          if (cnt_q == IW'(WPR - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_idx_o = cnt_q;
  assign axon_o     = axon_q;

endmodule

// File: rtl/synapse_matrix_param.sv
// rtl/synapse_matrix_param.sv - synapse crossbar store with Wishbone access and arbitrated row fetch port
module synapse_matrix_param
  import synapse_pkg::*;
#(
  parameter int          NUM_NEURONS = 256,
  parameter int          NUM_AXONS   = 256,
  parameter logic [31:0] BASE_ADDR   = SYN_BASE_ADDR
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  input  logic                        row_req_i,
  input  logic [clog2(NUM_AXONS)-1:0] row_axon_i,
  output logic                        row_busy_o,
  output logic                        row_valid_o,
  output logic [NUM_NEURONS-1:0]      row_data_o
);

  localparam int WPR   = NUM_NEURONS / WB_WORD_W;
  localparam int DEPTH = NUM_AXONS * WPR;
  localparam int AXW   = clog2(NUM_AXONS);
  localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int IW    = (WPR > 1) ? clog2(WPR) : 1;

  logic [WB_WORD_W-1:0]   mem [DEPTH];

  logic                   wb_req;
  logic [31:0]            wb_off;
  logic                   wb_in_rng;
  logic [AW-1:0]          wb_widx;
  logic [WB_WORD_W-1:0]   wb_rd_word;

  logic                   ack_q, ack_d;
  logic [WB_WORD_W-1:0]   dat_q, dat_d;
  logic [NUM_NEURONS-1:0] row_data_q, row_data_d;

  logic                   cap_en;
  logic [IW-1:0]          word_idx;
  logic [AXW-1:0]         fetch_axon;
  logic [AW-1:0]          fetch_addr;
  logic [WB_WORD_W-1:0]   fetch_word;

  // A request is only seen while ack is low, so each bus access owns exactly one port cycle.
  assign wb_req     = wbs_cyc_i && wbs_stb_i && !ack_q;
  assign wb_off     = wbs_adr_i - BASE_ADDR;
  assign wb_in_rng  = (wbs_adr_i >= BASE_ADDR) && ((wb_off >> 2) < 32'(DEPTH));
  assign wb_widx    = wb_off[AW+1:2];
  assign wb_rd_word = mem[wb_widx];

  assign fetch_addr = AW'(fetch_axon) * AW'(WPR) + AW'(word_idx);
  assign fetch_word = mem[fetch_addr];

  synapse_row_fetch_fsm #(
    .NUM_AXONS (NUM_AXONS),
    .WPR       (WPR),
    .AXW       (AXW),
    .IW        (IW)
  ) u_fetch (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .row_req_i  (row_req_i),
    .row_axon_i (row_axon_i),
    .grant_i    (!wb_req),
    .busy_o     (row_busy_o),
    .valid_o    (row_valid_o),
    .cap_en_o   (cap_en),
    .word_idx_o (word_idx),
    .axon_o     (fetch_axon)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_req && wbs_we_i && wb_in_rng) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) mem[wb_widx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    ack_d      = wb_req;
    dat_d      = (wb_req && !wbs_we_i && wb_in_rng) ? wb_rd_word : '0;
    row_data_d = row_data_q;
    if (cap_en) row_data_d[word_idx*WB_WORD_W +: WB_WORD_W] = fetch_word;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      row_data_q <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      row_data_q <= row_data_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign row_data_o = row_data_q;

endmodule

// File: tb/tb_synapse_matrix_param.sv
// tb/tb_synapse_matrix_param.sv - randomized self-checking bench for synapse_matrix_param
module tb_synapse_matrix_param;

  localparam int          NN    = 256;
  localparam int          NA    = 256;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          WPR   = NN / 32;
  localparam int          DEPTH = NA * WPR;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]    wbs_sel;
  logic [31:0]   wbs_adr, wbs_dat;
  logic          wbs_ack;
  logic [31:0]   wbs_dat_o;
  logic          row_req;
  logic [7:0]    row_axon;
  logic          row_busy, row_valid;
  logic [NN-1:0] row_data;

  always #5 wb_clk = ~wb_clk;

  synapse_matrix_param #(
    .NUM_NEURONS (NN),
    .NUM_AXONS   (NA),
    .BASE_ADDR   (BASE)
  ) dut (
    .wb_clk_i    (wb_clk),
    .wb_rst_i    (wb_rst),
    .wbs_cyc_i   (wbs_cyc),
    .wbs_stb_i   (wbs_stb),
    .wbs_we_i    (wbs_we),
    .wbs_sel_i   (wbs_sel),
    .wbs_adr_i   (wbs_adr),
    .wbs_dat_i   (wbs_dat),
    .wbs_ack_o   (wbs_ack),
    .wbs_dat_o   (wbs_dat_o),
    .row_req_i   (row_req),
    .row_axon_i  (row_axon),
    .row_busy_o  (row_busy),
    .row_valid_o (row_valid),
    .row_data_o  (row_data)
  );

  // Reference view of the store and of what each output should be after the next edge.
  logic [31:0]   ref_mem [DEPTH];
  bit            ack_m, valid_m, f_active;
  logic [31:0]   dat_m;
  int            f_axon, f_idx, stalls;
  logic [NN-1:0] exp_row;
  int            lat_cnt, dut_lat, pulses;
  int            total, bad;
  bit            got_valid;

  task automatic chk(input string tag, input logic [NN-1:0] got, input logic [NN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ack_m    = 1'b0;
    dat_m    = '0;
    valid_m  = 1'b0;
    f_active = 1'b0;
    exp_row  = '0;
    lat_cnt  = 0;
  endtask

  task automatic tick();
    bit          req_seen, was_active, in_rng, vnext, anext;
    logic [31:0] off, dnext;
    int          widx;
    req_seen   = wbs_cyc && wbs_stb && !ack_m;
    off        = wbs_adr - BASE;
    in_rng     = (wbs_adr >= BASE) && ((off >> 2) < 32'(DEPTH));
    widx       = int'(off >> 2);
    was_active = f_active;
    vnext      = 1'b0;
    if (was_active) begin
      if (req_seen) stalls++;
      else begin
        exp_row[f_idx*32 +: 32] = ref_mem[f_axon*WPR + f_idx];
        f_idx++;
        if (f_idx == WPR) begin
          f_active = 1'b0;
          vnext    = 1'b1;
        end
      end
    end else if (row_req && !valid_m) begin
      f_active = 1'b1;
      f_axon   = int'(row_axon);
      f_idx    = 0;
      stalls   = 0;
    end
    if (f_active && !was_active) lat_cnt = 1;
    else if (lat_cnt > 0) lat_cnt++;
    anext = 1'b0;
    dnext = '0;
    if (req_seen) begin
      anext = 1'b1;
      if (in_rng) begin
        if (wbs_we) begin
          for (int b = 0; b < 4; b++)
            if (wbs_sel[b]) ref_mem[widx][8*b +: 8] = wbs_dat[8*b +: 8];
        end else begin
          dnext = ref_mem[widx];
        end
      end
    end
    ack_m   = anext;
    dat_m   = dnext;
    valid_m = vnext;
    @(posedge wb_clk);
    #1;
    chk("ack", wbs_ack, ack_m);
    chk("dat", wbs_dat_o, dat_m);
    chk("valid", row_valid, valid_m);
    chk("busy", row_busy, f_active);
    if (row_valid) begin
      pulses++;
      dut_lat = lat_cnt;
      lat_cnt = 0;
    end
    if (valid_m) chk("row", row_data, exp_row);
  endtask

  task automatic wb_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic ack_o, output logic [31:0] rd_o);
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    wbs_we  = we;
    wbs_adr = a;
    wbs_dat = d;
    wbs_sel = s;
    tick();
    ack_o   = wbs_ack;
    rd_o    = wbs_dat_o;
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    tick();
  endtask

  logic        ack_r;
  logic [31:0] rd_r;

  initial begin
    total = 0;
    bad   = 0;
    pulses = 0;
    stalls = 0;
    wb_rst = 1'b1;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
    row_req = 0; row_axon = 0;
    model_reset();
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_ack", wbs_ack, 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_busy", row_busy, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_row", row_data, 0);
    wb_rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) wb_op(1, BASE + 32'(4*w), $urandom, 4'hF, ack_r, rd_r);

    // Full-word write then readback.
    wb_op(1, BASE, 32'hDEADBEEF, 4'hF, ack_r, rd_r);
    wb_op(0, BASE, 32'h0, 4'h0, ack_r, rd_r);
    chk("t2_ack", ack_r, 1);
    chk("t2_dat", rd_r, 32'hDEADBEEF);

    // Single byte lane merge.
    wb_op(1, BASE + 32'h4, 32'h11223344, 4'hF, ack_r, rd_r);
    wb_op(1, BASE + 32'h4, 32'h0000AA00, 4'b0010, ack_r, rd_r);
    wb_op(0, BASE + 32'h4, 32'h0, 4'h0, ack_r, rd_r);
    chk("t3_dat", rd_r, 32'h1122AA44);

    // Out-of-range accesses above and below the window.
    wb_op(0, BASE + 32'(4*DEPTH), 32'h0, 4'h0, ack_r, rd_r);
    chk("t4_rd_ack", ack_r, 1);
    chk("t4_rd_dat", rd_r, 0);
    wb_op(1, BASE + 32'(4*DEPTH), 32'hCAFEF00D, 4'hF, ack_r, rd_r);
    chk("t4_wr_ack", ack_r, 1);
    wb_op(1, BASE - 32'h4, 32'h12345678, 4'hF, ack_r, rd_r);
    chk("t4_lo_ack", ack_r, 1);
    for (int w = 0; w < DEPTH; w++) wb_op(0, BASE + 32'(4*w), 32'h0, 4'h0, ack_r, rd_r);

    // Uncontended fetch of a known row, with an ignored second request.
    for (int k = 0; k < WPR; k++) wb_op(1, BASE + 32'(4*(3*WPR + k)), 32'(k), 4'hF, ack_r, rd_r);
    row_req = 1'b1; row_axon = 8'd3;
    got_valid = 1'b0;
    dut_lat = 0;
    for (int i = 0; i < 40 && !got_valid; i++) begin
      tick();
      row_req = (i == 2);
      row_axon = (i == 2) ? 8'd7 : 8'd3;
      if (row_valid) got_valid = 1'b1;
    end
    row_req = 1'b0;
    chk("t5_done", got_valid, 1);
    chk("t5_lat", 32'(dut_lat), 32'(WPR + 1));
    for (int k = 0; k < WPR; k++) chk("t5_word", row_data[32*k +: 32], 32'(k));
    tick();

    // Reset in the middle of a fetch while a read is being acknowledged.
    row_req = 1'b1; row_axon = 8'd3;
    tick();
    row_req = 1'b0;
    repeat (3) tick();
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = BASE + 32'(4*(3*WPR + 5));
    tick();
    chk("t1_pre_dat", wbs_dat_o, 32'd5);
    wbs_cyc = 0; wbs_stb = 0;
    #2 wb_rst = 1'b1;
    model_reset();
    #1;
    chk("t1_busy", row_busy, 0);
    chk("t1_valid", row_valid, 0);
    chk("t1_row", row_data, 0);
    chk("t1_dat", wbs_dat_o, 0);
    chk("t1_ack", wbs_ack, 0);
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    pulses = 0;
    repeat (12) tick();
    chk("t1_nopulse", 32'(pulses), 0);

    // Continuous reads during a fetch: every port cycle taken by the bus stalls the fetch.
    row_req = 1'b1; row_axon = 8'd5;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = BASE + 32'(4*$urandom_range(DEPTH-1));
    got_valid = 1'b0;
    for (int i = 0; i < 100 && !got_valid; i++) begin
      tick();
      row_req = 1'b0;
      if (wbs_ack) wbs_adr = BASE + 32'(4*$urandom_range(DEPTH-1));
      if (row_valid) got_valid = 1'b1;
    end
    wbs_cyc = 0; wbs_stb = 0;
    chk("t6_done", got_valid, 1);
    chk("t6_stalled", 32'(stalls > 0), 1);
    chk("t6_lat", 32'(dut_lat), 32'(WPR + 1 + stalls));
    repeat (2) tick();

    // Random bus traffic (reads, byte writes, in-row and out-of-range) racing random fetches.
    for (int r = 0; r < 24; r++) begin
      int ax;
      ax = $urandom_range(NA-1);
      row_req = 1'b1; row_axon = 8'(ax);
      got_valid = 1'b0;
      for (int i = 0; i < 200 && !got_valid; i++) begin
        int sel_kind;
        sel_kind = $urandom_range(9);
        wbs_cyc = ($urandom_range(2) != 0);
        wbs_stb = wbs_cyc;
        wbs_we  = $urandom_range(1);
        wbs_sel = 4'($urandom);
        wbs_dat = $urandom;
        if (sel_kind < 5)      wbs_adr = BASE + 32'(4*(ax*WPR + $urandom_range(WPR-1)));
        else if (sel_kind < 9) wbs_adr = BASE + 32'(4*$urandom_range(DEPTH-1));
        else                   wbs_adr = BASE + 32'(4*DEPTH) + 32'(4*$urandom_range(15));
        tick();
        row_req = 1'b0;
        if (row_valid) got_valid = 1'b1;
      end
      wbs_cyc = 0; wbs_stb = 0;
      chk("t7_done", got_valid, 1);
      repeat (2) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
